// File: rtl/osd_dii_arbiter.sv
// osd_dii_arbiter: packet-atomic round-robin arbiter of NUM_IN DII flit sources onto debug_out.
// Flit layout {valid, last, data[15:0]}; define OSD_DII_ARB_PRIO0_EN to give source 0 fixed priority.
module osd_dii_arbiter #(
    parameter int NUM_IN      = 2,
    parameter int MAX_PKT_LEN = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*18-1:0]      in_flit,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [17:0]               debug_out,
    input  logic                      debug_out_ready,
    output logic [$clog2(NUM_IN)-1:0] grant_id,
    output logic                      err_oversize
);
    // state | meaning
    // IDLE  | no grant held; arbitrate among valid sources
    // PASS  | granted source drives debug_out until its last (or a forced last)
    // DRAIN | packet was truncated; discard source flits up to its own last

    localparam int GW = $clog2(NUM_IN);
`ifdef OSD_DII_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif
    // With source 0 on fixed priority, round-robin only covers sources 1..NUM_IN-1.
    localparam int RR_LO = PRIO0 ? 1 : 0;

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    state_t            state;
    state_t            next_state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     win_hi;
    logic [GW-1:0]     win_lo;
    logic              found_hi;
    logic [NUM_IN-1:0] src_valid;
    logic [17:0]       sel_flit;
    logic              sel_valid;
    logic              sel_last;
    logic              hs;
    logic              trunc;
    logic              pkt_end;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign src_valid[i] = in_flit[i*18+17];
    end

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == GW'(i)) sel_flit = in_flit[i*18 +: 18];
        end
    end

    assign sel_valid = sel_flit[17];
    assign sel_last  = sel_flit[16];
    assign hs        = (state == PASS) && sel_valid && debug_out_ready;
    assign pkt_end   = hs && (sel_last || trunc);

    // Lowest valid index above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_IN - 1; i >= RR_LO; i--) begin
            if (src_valid[i]) begin
                if (GW'(i) > rr_ptr) begin
                    win_hi   = GW'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo = GW'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
        if (PRIO0 && src_valid[0]) winner = '0;
    end

    if (MAX_PKT_LEN > 0) begin : g_guard
        localparam int CW = $clog2(MAX_PKT_LEN + 1);
        logic [CW-1:0] cnt;

        assign trunc = (cnt == CW'(MAX_PKT_LEN - 1)) && !sel_last;

        always_ff @(posedge clk) begin
            if (rst)          cnt <= '0;
            else if (pkt_end) cnt <= '0;
            else if (hs)      cnt <= cnt + 1'b1;
        end
    end else begin : g_no_guard
        assign trunc = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|src_valid) next_state = PASS;
            PASS:    if (pkt_end) next_state = trunc ? DRAIN : IDLE;
            DRAIN:   if (sel_valid && sel_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = '0;
        debug_out    = '0;
        err_oversize = 1'b0;
        case (state)
            PASS: begin
                debug_out = {sel_valid, sel_last || trunc, sel_flit[15:0]};
                for (int i = 0; i < NUM_IN; i++) begin
                    if (grant == GW'(i)) in_ready[i] = debug_out_ready;
                end
                err_oversize = hs && trunc;
            end
            DRAIN: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (grant == GW'(i)) in_ready[i] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= '0;
            rr_ptr <= GW'(NUM_IN - 1);
        end else begin
            if (state == IDLE && |src_valid) grant <= winner;
            if (pkt_end && !(PRIO0 && grant == '0)) rr_ptr <= grant;
        end
    end

    assign grant_id = grant;

endmodule

// File: tb/tb_osd_dii_arbiter.sv
// Scoreboard bench for osd_dii_arbiter with NUM_IN=3, MAX_PKT_LEN=4.
// Expected order follows OSD_DII_ARB_PRIO0_EN when the bench is built with it.
module tb_osd_dii_arbiter;
    localparam int N    = 3;
    localparam int MAXL = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*18-1:0] in_flit;
    logic [N-1:0]   in_ready;
    logic [17:0]    debug_out;
    logic           debug_out_ready;
    logic [1:0]     grant_id;
    logic           err_oversize;

    always #5 clk = ~clk;

    osd_dii_arbiter #(.NUM_IN(N), .MAX_PKT_LEN(MAXL)) dut (
        .clk(clk),
        .rst(rst),
        .in_flit(in_flit),
        .in_ready(in_ready),
        .debug_out(debug_out),
        .debug_out_ready(debug_out_ready),
        .grant_id(grant_id),
        .err_oversize(err_oversize)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] src_q[N][$];
    int          hs_cyc[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          err_cyc = -1;
    logic [17:0] snap_out;
    logic [N-1:0] snap_ready;
    logic [1:0]  snap_grant;

    task automatic drive();
        for (int i = 0; i < N; i++)
            in_flit[i*18 +: 18] = (src_q[i].size() > 0) ? {1'b1, src_q[i][0]} : 18'd0;
    endtask

    task automatic add_pkt(input int s, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) src_q[s].push_back({(k == n - 1), base + 16'(k)});
    endtask

    task automatic exp_flit(input int s, input logic last, input logic [15:0] data);
        exp_t e;
        e.src = 2'(s); e.last = last; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int s, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) exp_flit(s, (k == n - 1), base + 16'(k));
    endtask

    // One clock: monitor at negedge, then advance sources after the rising edge.
    task automatic tick();
        exp_t e;
        logic [N-1:0] hs;
        @(negedge clk);
        snap_out   = debug_out;
        snap_ready = in_ready;
        snap_grant = grant_id;
        if (err_oversize) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (debug_out[17] && debug_out_ready) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_flit cyc=%0d got=%h required=none", cyc, debug_out);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, debug_out[16:0]} !== e) begin
                    failures++;
                    $display("FAIL flit cyc=%0d got src=%0d last=%0b data=%h required src=%0d last=%0b data=%h",
                             cyc, grant_id, debug_out[16], debug_out[15:0], e.src, e.last, e.data);
                end
            end
        end
        for (int i = 0; i < N; i++) hs[i] = in_flit[i*18+17] & in_ready[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
        drive();
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        debug_out_ready = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start();
        drive();
        cyc = 0;
        hs_cyc.delete();
        err_cnt = 0;
        err_cyc = -1;
    endtask

    task automatic run_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (snap_ready !== 3'b000) begin failures++; $display("FAIL rst_in_ready got=%b required=000", snap_ready); end
        if (snap_out[17] !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", snap_out[17]); end
        if (snap_grant !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d required=0", snap_grant); end
        if (err_cnt !== 0) begin failures++; $display("FAIL rst_err got=%0d required=0", err_cnt); end
        start();
        tick();
        checks += 2;
        if (snap_out[17] !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b required=0", snap_out[17]); end
        if (snap_ready !== 3'b000) begin failures++; $display("FAIL idle_in_ready got=%b required=000", snap_ready); end
    endtask

    task automatic test_reset_grant();
        int exp_c[6] = '{1, 2, 3, 5, 6, 7};
        do_reset();
        add_pkt(0, 3, 16'h0100);
        add_pkt(1, 3, 16'h0200);
        exp_pkt(0, 3, 16'h0100);
        exp_pkt(1, 3, 16'h0200);
        start();
        run_drain(30, "reset_grant");
        checks++;
        if (hs_cyc.size() !== 6) begin
            failures++;
            $display("FAIL reset_grant_count got=%0d required=6", hs_cyc.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (hs_cyc[k] !== exp_c[k]) begin
                    failures++;
                    $display("FAIL reset_grant_cycle flit=%0d got=%0d required=%0d", k, hs_cyc[k], exp_c[k]);
                end
            end
        end
    endtask

    task automatic test_fairness();
`ifdef OSD_DII_ARB_PRIO0_EN
        int ord_s[6] = '{0, 0, 1, 2, 1, 2};
        int ord_p[6] = '{0, 1, 0, 0, 1, 1};
`else
        int ord_s[6] = '{0, 1, 2, 0, 1, 2};
        int ord_p[6] = '{0, 0, 0, 1, 1, 1};
`endif
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) add_pkt(s, 2, 16'(16'h1000 + s * 16'h100 + p * 16'h10));
        for (int k = 0; k < 6; k++)
            exp_pkt(ord_s[k], 2, 16'(16'h1000 + ord_s[k] * 16'h100 + ord_p[k] * 16'h10));
        start();
        run_drain(60, "fairness");
        checks++;
        if (err_cnt !== 0) begin failures++; $display("FAIL fairness_err got=%0d required=0", err_cnt); end
    endtask

    task automatic test_backpressure();
        logic pat[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [N-1:0] want_rdy;
        do_reset();
        add_pkt(1, 4, 16'h0300);
        exp_pkt(1, 4, 16'h0300);
        start();
        for (int c = 0; c < 7; c++) begin
            debug_out_ready = pat[c];
            tick();
            if (c == 1) begin
                add_pkt(0, 1, 16'h0400);
                add_pkt(2, 1, 16'h0500);
`ifdef OSD_DII_ARB_PRIO0_EN
                exp_pkt(0, 1, 16'h0400);
                exp_pkt(2, 1, 16'h0500);
`else
                exp_pkt(2, 1, 16'h0500);
                exp_pkt(0, 1, 16'h0400);
`endif
                drive();
            end
            if (c >= 1) begin
                want_rdy = pat[c] ? 3'b010 : 3'b000;
                checks += 2;
                if (snap_ready !== want_rdy) begin
                    failures++;
                    $display("FAIL bp_in_ready cyc=%0d got=%b required=%b", c, snap_ready, want_rdy);
                end
                if (snap_grant !== 2'd1) begin
                    failures++;
                    $display("FAIL bp_grant cyc=%0d got=%0d required=1", c, snap_grant);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (snap_out !== {1'b1, 1'b0, 16'h0301}) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got=%h required=%h", c, snap_out, {1'b1, 1'b0, 16'h0301});
                end
            end
        end
        debug_out_ready = 1'b1;
        run_drain(30, "backpressure");
        checks++;
        if (err_cnt !== 0) begin failures++; $display("FAIL bp_last_at_max_err got=%0d required=0", err_cnt); end
    endtask

    task automatic test_oversize();
        do_reset();
        add_pkt(2, 7, 16'h0600);
        for (int k = 0; k < 4; k++) exp_flit(2, (k == 3), 16'(16'h0600 + k));
        start();
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 4) begin
                add_pkt(1, 1, 16'h0700);
                exp_pkt(1, 1, 16'h0700);
                drive();
            end
            if (c >= 5 && c <= 7) begin
                checks += 2;
                if (snap_out[17] !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_valid cyc=%0d got=%b required=0", c, snap_out[17]);
                end
                if (snap_ready !== 3'b100) begin
                    failures++;
                    $display("FAIL drain_in_ready cyc=%0d got=%b required=100", c, snap_ready);
                end
            end
        end
        run_drain(20, "oversize");
        checks += 4;
        if (err_cnt !== 1) begin failures++; $display("FAIL oversize_err_count got=%0d required=1", err_cnt); end
        if (err_cyc !== 4) begin failures++; $display("FAIL oversize_err_cycle got=%0d required=4", err_cyc); end
        if (src_q[2].size() !== 0) begin failures++; $display("FAIL oversize_drained left=%0d required=0", src_q[2].size()); end
        if (hs_cyc.size() !== 5 || hs_cyc[hs_cyc.size()-1] !== 9) begin
            failures++;
            $display("FAIL oversize_next_arb count=%0d required_count=5 last_cycle_required=9", hs_cyc.size());
        end
    endtask

    task automatic test_priority();
        do_reset();
        add_pkt(1, 3, 16'h0800);
        add_pkt(1, 3, 16'h0810);
        add_pkt(2, 3, 16'h0900);
        add_pkt(2, 3, 16'h0910);
        exp_pkt(1, 3, 16'h0800);
        start();
        tick();
        tick();
        add_pkt(0, 2, 16'h0A00);
`ifdef OSD_DII_ARB_PRIO0_EN
        exp_pkt(0, 2, 16'h0A00);
        exp_pkt(2, 3, 16'h0900);
`else
        exp_pkt(2, 3, 16'h0900);
        exp_pkt(0, 2, 16'h0A00);
`endif
        exp_pkt(1, 3, 16'h0810);
        exp_pkt(2, 3, 16'h0910);
        drive();
        run_drain(80, "priority");
    endtask

    task automatic test_reset_mid();
        int exp_c[5] = '{1, 3, 4, 6, 8};
        do_reset();
        add_pkt(0, 1, 16'h0B00);
        add_pkt(0, 5, 16'h0B10);
        exp_pkt(0, 1, 16'h0B00);
        exp_flit(0, 1'b0, 16'h0B10);
        exp_flit(0, 1'b0, 16'h0B11);
        start();
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_q[0].delete();
        add_pkt(0, 1, 16'h0C00);
        add_pkt(1, 1, 16'h0D00);
        exp_pkt(0, 1, 16'h0C00);
        exp_pkt(1, 1, 16'h0D00);
        drive();
        tick();
        checks += 2;
        if (snap_out[17] !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b required=0", snap_out[17]); end
        if (snap_ready !== 3'b000) begin failures++; $display("FAIL rst_mid_in_ready got=%b required=000", snap_ready); end
        run_drain(20, "reset_mid");
        checks++;
        if (hs_cyc.size() !== 5) begin
            failures++;
            $display("FAIL rst_mid_count got=%0d required=5", hs_cyc.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (hs_cyc[k] !== exp_c[k]) begin
                    failures++;
                    $display("FAIL rst_mid_cycle flit=%0d got=%0d required=%0d", k, hs_cyc[k], exp_c[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        debug_out_ready = 1'b1;
        in_flit = '0;
        test_reset();
        test_reset_grant();
        test_fairness();
        test_backpressure();
        test_oversize();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osd_dii_arbiter.md
# osd_dii_arbiter

Packet-level arbiter sharing one Debug Interconnect Interface (DII) output among `NUM_IN` flit sources inside a debug module. Typical sources are the register-access response path and event/trace packetizers, all feeding the module's single `debug_out` toward the debug ring. Packets are never interleaved. A grant is held from first flit to `last`. An optional oversize guard truncates runaway packets at `MAX_PKT_LEN`.

## Interface
Parameters:
- `NUM_IN`, default 2: number of requesting flit sources. Legal range 2..16.
- `MAX_PKT_LEN`, default 0: maximum flits per packet. 0 disables the length guard.

Ports:
- `clk`  input  1  clock; everything is synchronous to its rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_flit`  input  dii_flit [NUM_IN]  source flits (`valid`, `last`, `data[15:0]`).
- `in_ready`  output  NUM_IN  per-source ready.
- `debug_out`  output  dii_flit  arbitrated flit stream.
- `debug_out_ready`  input  1  downstream ready.
- `grant_id`  output  $clog2(NUM_IN)  currently granted source. Meaningful in PASS/DRAIN.
- `err_oversize`  output  1  one-cycle pulse when a packet is truncated.

## Operation
Three-state FSM: IDLE, PASS, DRAIN.

- **IDLE**
  - All `in_ready` = 0; `debug_out.valid` = 0.
  - If any `in_flit[i].valid`: register `grant` = round-robin winner, searching from `rr_ptr+1` upward with wrap. Go to PASS.
- **PASS**
  - `debug_out` = `in_flit[grant]`; `in_ready[grant]` = `debug_out_ready`; all other `in_ready` = 0.
  - A handshake is `valid & debug_out_ready`. On each handshake, increment `cnt`.
  - Handshake with `last` = 1: `rr_ptr` ← `grant`, `cnt` ← 0, go to IDLE.
  - Oversize truncation applies when `MAX_PKT_LEN` > 0, `cnt` == `MAX_PKT_LEN-1` and the source flit has `last` = 0:
    - drive `debug_out.last` = 1 (forced);
    - on handshake, pulse `err_oversize`, clear `cnt`, set `rr_ptr` ← `grant`, go to DRAIN.
- **DRAIN**
  - `debug_out.valid` = 0; `in_ready[grant]` = 1, discarding flits.
  - On a discarded flit with `last` = 1, go to IDLE.
- **Counter and pointer**
  - `cnt` width is $clog2(MAX_PKT_LEN+1). It is unused and tied to 0 when `MAX_PKT_LEN` = 0.
  - Reset value of `rr_ptr` is `NUM_IN-1`, so source 0 wins the first arbitration.
- **Stability**
  - Once granted, a source is never preempted, whatever other requests arrive.
  - Valid/data stability on `debug_out` follows from the source's own stability.

## Timing
- Reset values: state IDLE; `grant` 0; `cnt` 0; `rr_ptr` NUM_IN-1; `in_ready` all 0; `debug_out.valid` 0; `err_oversize` 0.
- Arbitration costs exactly one bubble cycle per packet. A request seen in IDLE at cycle N can hand off its first flit at cycle N+1 at the earliest.
- The PASS datapath is combinational: `debug_out` follows `in_flit[grant]`, and `in_ready[grant]` follows `debug_out_ready`.
- Single-flit packet (`valid` & `last` in the first PASS cycle): PASS lasts one cycle when `debug_out_ready` = 1, and the FSM is back in IDLE the next cycle.
- A valid source flit held while `debug_out_ready` = 0 stalls PASS indefinitely. There is no timeout.
- `MAX_PKT_LEN` = 1: every non-last first flit is forced `last` and the rest of that packet is drained.
- Flit reaching `MAX_PKT_LEN` that already carries `last`: normal completion, no error.
- `rst` asserted mid-packet: the FSM returns to IDLE next cycle and `rr_ptr` is reinitialised. The partial packet is abandoned; no forced `last` is emitted.

## Configuration
- Macro `OSD_DII_ARB_PRIO0_EN`.
- Defined: in IDLE, source 0 wins whenever `in_flit[0].valid` is set. Remaining sources arbitrate round-robin among themselves, and `rr_ptr` only advances over sources 1..NUM_IN-1. Packet atomicity is unchanged; source 0 still never preempts a packet in progress.
- Undefined: pure round-robin across all sources, as described in Operation.

## Test plan
- **Reset grant:** after `rst`, sources 0 and 1 request simultaneously with 3-flit packets, `debug_out_ready`=1. Required: packet 0 flits appear at cycles 1–3, bubble, then packet 1 at cycles 5–7; no interleaving.
- **Fairness:** `NUM_IN`=3, all sources request continuously. Required: grant order 0,1,2,0,1,2; `grant_id` matches each packet.
- **Backpressure:** `debug_out_ready` toggles 1,0,0,1 during a 4-flit packet. Required: `debug_out` data/valid held stable while ready=0; `in_ready[grant]` mirrors `debug_out_ready`; other `in_ready` stay 0.
- **Oversize:** `MAX_PKT_LEN`=4, source sends a 7-flit packet. Required: 4 flits out with the 4th `last`=1; `err_oversize` high for one cycle; 3 flits drained with `in_ready`=1 and `debug_out.valid`=0; next arbitration follows.
- **Priority build:** `OSD_DII_ARB_PRIO0_EN` defined, sources 1 and 2 streaming, source 0 requesting mid-packet of source 1. Required: source 1's packet completes, then source 0 is granted before source 2.
- **Reset mid-packet:** `rst` pulsed at flit 2 of a 5-flit packet. Required: `debug_out.valid`=0 the next cycle, state IDLE, and source 0 is the next winner.
